// File: rtl/crc_cdc_pkg.sv
// Shared definitions for the CRC CDC pipeline front end: message width,
// scheduler state encoding and CRC polynomial select codes.
package crc_cdc_pkg;

  localparam int MSG_W = 58;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } sched_state_e;

  localparam logic CRC_SEL_POLY0 = 1'b0;
  localparam logic CRC_SEL_POLY1 = 1'b1;

endpackage

// File: rtl/toggle_sync_rx.sv
// Receives an asynchronous toggle into clk_1: SYNC_STAGES flop chain plus one
// history flop, edge_o is high for one cycle per toggle.
module toggle_sync_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_1,
  input  logic rst_n,
  input  logic tgl_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/crc_job_scheduler.sv
// Round-robin job scheduler in front of the CRC encode/check pipeline; one job in flight.
// Optional WAIT watchdog enabled by defining CRC_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrating, grant issued on any request
// LAUNCH | launch_valid pulse to datapath
// WAIT   | job in flight, waiting for synchronised done toggle
// GAP    | forced idle spacing before the next grant
module crc_job_scheduler
  import crc_cdc_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int MSG_W          = crc_cdc_pkg::MSG_W,
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_1,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*MSG_W-1:0]   req_message,
  input  logic [N_REQ-1:0]         req_mode,
  input  logic [N_REQ-1:0]         req_crc,
  output logic [N_REQ-1:0]         grant,
  output logic                     launch_valid,
  output logic [MSG_W-1:0]         launch_message,
  output logic                     launch_mode,
  output logic                     launch_crc,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  input  logic                     done_tgl,
  output logic                     done_pulse,
  output logic                     err_spurious,
  output logic                     err_timeout
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  sched_state_e     state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic             launch_valid_q, launch_mode_q, launch_crc_q, busy_q;
  logic [MSG_W-1:0] launch_message_q;
  logic [PTR_W-1:0] owner_q;
  logic             done_pulse_q, err_spurious_q;

  logic             done_edge;
  logic             win_found;
  logic [PTR_W-1:0] win_idx, win_nxt;
  int               cand;

  toggle_sync_rx #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .clk_1  (clk_1),
    .rst_n  (rst_n),
    .tgl_i  (done_tgl),
    .edge_o (done_edge)
  );

  // First requester at or above rr_ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    win_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

`ifdef CRC_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  logic [WD_W-1:0] wd_cnt_q;
  logic            err_timeout_q;
`endif

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      gap_cnt_q        <= '0;
      grant_q          <= '0;
      launch_valid_q   <= 1'b0;
      launch_message_q <= '0;
      launch_mode_q    <= 1'b0;
      launch_crc_q     <= CRC_SEL_POLY0;
      owner_q          <= '0;
      busy_q           <= 1'b0;
      done_pulse_q     <= 1'b0;
      err_spurious_q   <= 1'b0;
`ifdef CRC_SCHED_TIMEOUT_EN
      wd_cnt_q         <= '0;
      err_timeout_q    <= 1'b0;
`endif
    end else begin
      grant_q        <= '0;
      launch_valid_q <= 1'b0;
      done_pulse_q   <= 1'b0;
      if (done_edge && state_q != WAIT) err_spurious_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q[win_idx] <= 1'b1;
            owner_q          <= win_idx;
            launch_message_q <= req_message[int'(win_idx)*MSG_W +: MSG_W];
            launch_mode_q    <= req_mode[win_idx];
            launch_crc_q     <= req_crc[win_idx];
            rr_ptr_q         <= win_nxt;
            busy_q           <= 1'b1;
            state_q          <= LAUNCH;
          end
        end
        LAUNCH: begin
          launch_valid_q <= 1'b1;
          state_q        <= WAIT;
`ifdef CRC_SCHED_TIMEOUT_EN
          wd_cnt_q       <= WD_LOAD;
`endif
        end
        WAIT: begin
          // A done edge beats a simultaneous watchdog expiry.
          if (done_edge) begin
            done_pulse_q <= 1'b1;
            gap_cnt_q    <= GAP_LOAD;
            state_q      <= GAP;
          end
`ifdef CRC_SCHED_TIMEOUT_EN
          else if (wd_cnt_q == '0) begin
            err_timeout_q <= 1'b1;
            gap_cnt_q     <= GAP_LOAD;
            state_q       <= GAP;
          end else begin
            wd_cnt_q <= wd_cnt_q - WD_W'(1);
          end
`endif
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign launch_valid   = launch_valid_q;
  assign launch_message = launch_message_q;
  assign launch_mode    = launch_mode_q;
  assign launch_crc     = launch_crc_q;
  assign owner          = owner_q;
  assign busy           = busy_q;
  assign done_pulse     = done_pulse_q;
  assign err_spurious   = err_spurious_q;
`ifdef CRC_SCHED_TIMEOUT_EN
  assign err_timeout    = err_timeout_q;
`else
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_crc_job_scheduler.sv
// Scoreboard bench for crc_job_scheduler: stimulus queues expected grants and
// done pulses, a negedge monitor pops and compares them.
module tb_crc_job_scheduler;

  localparam int N = 4;
  localparam int W = 58;

  logic            clk_1 = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_message;
  logic [N-1:0]    req_mode, req_crc;
  logic [N-1:0]    grant;
  logic            launch_valid, launch_mode, launch_crc, busy;
  logic [W-1:0]    launch_message;
  logic [1:0]      owner;
  logic            done_tgl, done_pulse, err_spurious, err_timeout;

  crc_job_scheduler #(
    .N_REQ(N), .MSG_W(W), .SYNC_STAGES(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_1(clk_1), .rst_n(rst_n), .req(req), .req_message(req_message),
    .req_mode(req_mode), .req_crc(req_crc), .grant(grant),
    .launch_valid(launch_valid), .launch_message(launch_message),
    .launch_mode(launch_mode), .launch_crc(launch_crc), .owner(owner),
    .busy(busy), .done_tgl(done_tgl), .done_pulse(done_pulse),
    .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clk_1 = ~clk_1;

  int cyc = 0;
  always @(posedge clk_1) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] msg_tab [N];
  logic [N-1:0] mode_v = 4'b0101;
  logic [N-1:0] crc_v  = 4'b0110;
  int exp_w_q[$];
  int exp_done_q[$];
  int last_w = -1;
  int grant_cyc = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      int w;
      @(negedge clk_1);
      if (rst_n === 1'b1) begin
        if (grant != '0) begin
          if (exp_w_q.size() == 0) chk("unexpected_grant", grant, 0);
          else begin
            w = exp_w_q.pop_front();
            chk("grant", grant, 4'b0001 << w);
            chk("owner", owner, w);
            last_w    = w;
            grant_cyc = cyc;
          end
        end
        if (launch_valid) begin
          chk("launch_cycle", cyc, grant_cyc + 1);
          if (last_w >= 0) begin
            chk("launch_message", launch_message, msg_tab[last_w]);
            chk("launch_mode", launch_mode, mode_v[last_w]);
            chk("launch_crc", launch_crc, crc_v[last_w]);
          end
        end
        if (done_pulse) begin
          if (exp_done_q.size() == 0) chk("unexpected_done", done_pulse, 0);
          else chk("done_latency", cyc, exp_done_q.pop_front());
        end
      end
    end
  end

  task automatic wait_grant();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_1);
      if (grant != '0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL grant_wait: no grant within 30 cycles (cycle %0d)", cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the launch cycle (or after GAP).
  task automatic run_job(input logic [N-1:0] req_v, input int exp_w, input bit drop, input bit do_done);
    req = req_v;
    exp_w_q.push_back(exp_w);
    wait_grant();
    if (drop) req[exp_w] = 1'b0;
    @(negedge clk_1);
    if (do_done) begin
      repeat (10) @(negedge clk_1);
      done_tgl = ~done_tgl;
      exp_done_q.push_back(cyc + 3);
      repeat (4) @(negedge clk_1);
      chk("busy_in_gap", busy, 1);
      @(negedge clk_1);
      chk("busy_after_gap", busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_launch_valid"}, launch_valid, 0);
    chk({tag, "_launch_message"}, launch_message, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_done_pulse"}, done_pulse, 0);
    chk({tag, "_err_spurious"}, err_spurious, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    int k;
    bit seen;
    rst_n = 1'b0;
    req = '0;
    done_tgl = 1'b0;
    msg_tab[0] = 58'h0AA_0000;
    msg_tab[1] = 58'h155;
    msg_tab[2] = 58'h2_0000_0000_0002;
    msg_tab[3] = 58'h3FF_FFFF_FFFF_FFFF;
    req_message = {msg_tab[3], msg_tab[2], msg_tab[1], msg_tab[0]};
    req_mode = mode_v;
    req_crc  = crc_v;
    repeat (3) @(negedge clk_1);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_1);

    run_job(4'b0010, 1, 1'b1, 1'b1);
    chk("launch_msg_held", launch_message, 58'h155);

    done_tgl = ~done_tgl;
    repeat (5) @(negedge clk_1);
    chk("err_spurious_set", err_spurious, 1);
    chk("spurious_busy", busy, 0);

    rst_n = 1'b0;
    done_tgl = 1'b0;
    @(negedge clk_1);
    chk("err_spurious_cleared", err_spurious, 0);
    rst_n = 1'b1;
    @(negedge clk_1);

    run_job(4'b1001, 0, 1'b0, 1'b1);
    run_job(4'b1001, 3, 1'b0, 1'b1);
    run_job(4'b1001, 0, 1'b0, 1'b1);
    run_job(4'b1001, 3, 1'b0, 1'b1);
    run_job(4'b1111, 0, 1'b0, 1'b1);
    run_job(4'b1111, 1, 1'b0, 1'b1);
    run_job(4'b1111, 2, 1'b0, 1'b1);
    run_job(4'b1111, 3, 1'b0, 1'b1);
    run_job(4'b1111, 0, 1'b0, 1'b1);

    run_job(4'b1111, 1, 1'b0, 1'b0);
    repeat (5) @(negedge clk_1);
    chk("busy_in_wait", busy, 1);
    rst_n = 1'b0;
    done_tgl = 1'b0;
    #1;
    check_all_zero("midreset");
    req = 4'b0100;
    @(negedge clk_1);
    rst_n = 1'b1;
    run_job(4'b0100, 2, 1'b1, 1'b1);

`ifdef CRC_SCHED_TIMEOUT_EN
    run_job(4'b0001, 0, 1'b0, 1'b0);
    k = cyc - 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (err_timeout) seen = 1'b1;
      else @(negedge clk_1);
    end
    chk("timeout_cycle", cyc, k + 17);
    chk("timeout_no_done_pulse", done_pulse, 0);
    exp_w_q.push_back(0);
    wait_grant();
    chk("regrant_cycle", cyc, k + 20);
    req = '0;
    @(negedge clk_1);
`else
    chk("err_timeout_tied", err_timeout, 0);
    seen = 1'b0;
    k = 0;
`endif

    repeat (5) @(negedge clk_1);
    chk("pending_grants", exp_w_q.size(), 0);
    chk("pending_dones", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
